// File: rtl/multicycle_decode.sv
// Multicycle ARM control FSM: sequences fetch/decode/memory/ALU/branch steps,
// gates side effects on CondEx, and runs a start/done handshake with an FP adder.
module multicycle_decode #(
    parameter int ALUCTRL_W  = 3,
    parameter int FP_EN      = 1,
    parameter int FP_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic                 CondEx,
    input  logic                 FPDone,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic                 AdrSrc,
    output logic [1:0]           ResultSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [1:0]           FlagW,
    output logic                 FPStart,
    output logic                 FPErr,
    output logic                 IllegalOp
);

    localparam int              CNT_W    = $clog2(FP_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FP_TIMEOUT - 1);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        FPWAIT = 4'd10
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_write;
        logic       adr_src;
        logic [1:0] result_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
        logic [2:0] alu_ctrl;
        logic [1:0] flag_w;
        logic       fp_start;
        logic       fp_err;
        logic       illegal;
    } ctrl_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    ctrl_t            ctrl;
    logic [2:0]       alu_op;
    logic             alu_undef;
    logic             is_fadd;
    logic             is_addsub;
    logic             rd_is_pc;
    logic [2:0]       alu_ctrl3;

    // run_q holds the FSM (and the outputs) idle until the first edge after reset release.
    assign run_d    = 1'b1;
    assign rd_is_pc = (Rd == 4'hF);

    // NOTE: the reset branch clears every flop asynchronously; outputs are gated by run_q, not reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        alu_op    = 3'b000;
        alu_undef = 1'b0;
        is_fadd   = 1'b0;
        unique case (Funct[4:1])
            4'b0100: alu_op = 3'b000;
            4'b0010: alu_op = 3'b001;
            4'b0000: alu_op = 3'b010;
            4'b1100: begin
                if (FP_EN != 0) begin
                    alu_op  = 3'b100;
                    is_fadd = 1'b1;
                end else begin
                    alu_op  = 3'b011;
                end
            end
            default: alu_undef = 1'b1;
        endcase
        is_addsub = (Funct[4:1] == 4'b0100) || (Funct[4:1] == 4'b0010);
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        ctrl    = '0;
        state_d = FETCH;
        case (state_q)
            FETCH: begin
                ctrl.ir_write   = 1'b1;
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = 2'b10;
                ctrl.result_src = 2'b10;
                ctrl.pc_write   = 1'b1;
                state_d         = DECODE;
            end
            DECODE: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = 2'b10;
                ctrl.result_src = 2'b10;
                case (Op)
                    2'b01:   state_d = MEMADR;
                    2'b00:   state_d = Funct[5] ? EXECI : EXECR;
                    2'b10:   state_d = BRANCH;
                    default: ctrl.illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                ctrl.alu_src_b = 2'b01;
                ctrl.imm_src   = 2'b01;
                state_d        = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                ctrl.adr_src = 1'b1;
                state_d      = MEMWB;
            end
            MEMWB: begin
                ctrl.result_src = 2'b01;
                ctrl.reg_write  = CondEx;
                ctrl.pc_write   = CondEx & rd_is_pc;
            end
            MEMWR: begin
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = CondEx;
                ctrl.reg_src   = 2'b10;
            end
            EXECR, EXECI: begin
                ctrl.alu_src_b = (state_q == EXECI) ? 2'b01 : 2'b00;
                if (alu_undef) begin
                    ctrl.illegal = 1'b1;
                end else if (is_fadd) begin
                    // Flags for FADD are written only once the adder reports a result.
                    ctrl.alu_ctrl = alu_op;
                    ctrl.fp_start = 1'b1;
                    state_d       = FPWAIT;
                end else begin
                    ctrl.alu_ctrl  = alu_op;
                    ctrl.flag_w[1] = Funct[0] & CondEx;
                    ctrl.flag_w[0] = Funct[0] & CondEx & is_addsub;
                    state_d        = ALUWB;
                end
            end
            ALUWB: begin
                ctrl.reg_write = CondEx;
                ctrl.pc_write  = CondEx & rd_is_pc;
            end
            BRANCH: begin
                ctrl.alu_src_b  = 2'b01;
                ctrl.imm_src    = 2'b10;
                ctrl.result_src = 2'b10;
                ctrl.pc_write   = CondEx;
            end
            FPWAIT: begin
                ctrl.alu_ctrl = 3'b100;
                if (FPDone) begin
                    ctrl.flag_w = {Funct[0] & CondEx, 1'b0};
                    state_d     = ALUWB;
                end else if (cnt_q == CNT_LAST) begin
                    ctrl.fp_err = 1'b1;
                end else begin
                    state_d = FPWAIT;
                end
            end
            default: state_d = FETCH;
        endcase

        cnt_d = (state_q == FPWAIT && state_d == FPWAIT) ? cnt_q + CNT_W'(1) : '0;
        if (!run_q) begin
            state_d = FETCH;
            cnt_d   = '0;
        end
    end

    assign {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
            ImmSrc, RegSrc, alu_ctrl3, FlagW, FPStart, FPErr, IllegalOp} = run_q ? ctrl : '0;
    assign ALUControl = ALUCTRL_W'(alu_ctrl3);

endmodule
